// File: rtl/spi_slave_if.sv
// spi_slave_if: serial front end of the SPI slave subsystem.
//   Shifts MOSI frames (MSB first, one bit per clk while SS_n is low) into
//   DATA_W+2 bit command words {cmd[1:0], payload}, and shifts the memory's
//   read response back out on MISO.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   SS_n            slave select (active low); high aborts any frame
//   MOSI / MISO     serial in / registered serial out, MSB first
//   rx_data         last completed command word, held until the next one
//   rx_valid        one-cycle strobe marking a newly completed rx_data
//   tx_data         read data from memory
//   tx_valid        tx_data strobe; only the first one of a read-data frame is used
module spi_slave_if #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int RX_W = DATA_W + 2;
  localparam int CW   = $clog2(RX_W);
  localparam int TW   = $clog2(DATA_W);
  // Bit counter value after the last payload bit has been taken.
  localparam logic [CW-1:0] CNT_DONE = CW'(RX_W - 2);
  localparam logic [TW-1:0] TX_REST  = TW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;          // payload bits taken so far
  logic [RX_W-2:0]   rx_sh_q;        // all bits of the frame except the last one
  logic [RX_W-1:0]   rx_data_q;
  logic              rx_valid_q;
  logic              rd_addr_held_q; // a read address has been latched, next read cmd is data
  logic [DATA_W-1:0] tx_sh_q;
  logic [TW-1:0]     tx_cnt_q;       // MISO bits still to be driven after the MSB
  logic              tx_used_q;      // this frame already consumed its tx_valid
  logic              miso_q;

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rx_sh_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_held_q <= 1'b0;
      tx_sh_q        <= '0;
      tx_cnt_q       <= '0;
      tx_used_q      <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (state_q == IDLE) begin
        miso_q <= 1'b0;
        if (!SS_n) state_q <= CHK_CMD;
      end else if (SS_n) begin
        // Deselect wins over everything, including a frame completing on this edge.
        state_q  <= IDLE;
        miso_q   <= 1'b0;
        tx_cnt_q <= '0;
      end else if (state_q == CHK_CMD) begin
        rx_sh_q   <= {{(RX_W-2){1'b0}}, MOSI};
        cnt_q     <= '0;
        tx_cnt_q  <= '0;
        tx_used_q <= 1'b0;
        miso_q    <= 1'b0;
        if (!MOSI)               state_q <= WRITE;
        else if (rd_addr_held_q) state_q <= READ_DATA;
        else                     state_q <= READ_ADD;
      end else if (cnt_q != CNT_DONE + 1'b1) begin
        // Collecting payload bits; MISO stays quiet.
        miso_q  <= 1'b0;
        rx_sh_q <= {rx_sh_q[RX_W-3:0], MOSI};
        cnt_q   <= cnt_q + 1'b1;
        if (cnt_q == CNT_DONE) begin
          rx_data_q  <= {rx_sh_q, MOSI};
          rx_valid_q <= 1'b1;
          // Command bits of the finished frame are rx_sh_q's top two bits.
          case (rx_sh_q[RX_W-2 -: 2])
            2'b10:   rd_addr_held_q <= 1'b1;
            2'b11:   rd_addr_held_q <= 1'b0;
            default: ;
          endcase
        end
      end else if (state_q == READ_DATA) begin
        if (tx_cnt_q != '0) begin
          miso_q   <= tx_sh_q[DATA_W-1];
          tx_sh_q  <= {tx_sh_q[DATA_W-2:0], 1'b0};
          tx_cnt_q <= tx_cnt_q - 1'b1;
        end else if (tx_valid && !tx_used_q) begin
          miso_q    <= tx_data[DATA_W-1];
          tx_sh_q   <= {tx_data[DATA_W-2:0], 1'b0};
          tx_cnt_q  <= TX_REST;
          tx_used_q <= 1'b1;
        end else begin
          miso_q <= 1'b0;
        end
      end else begin
        // WRITE / READ_ADD after completion: ignore MOSI until deselect.
        miso_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed bench for spi_slave_if. Expected command words go
// into a scoreboard queue when a full frame is driven and are popped by a
// monitor on each rx_valid; expected MISO bits are queued when read data is
// handed to the DUT and popped as the serial output is sampled.
module tb_spi_slave_if;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int errors = 0;
  int checks = 0;
  int rv_cnt = 0;
  logic [9:0] exp_q[$];
  logic       miso_q[$];

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every rx_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rv_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL rx_unexpected observed=%0h expected=none", rx_data);
      end
      if (exp_q.size() != 0) chk("rx_data", {22'd0, rx_data}, {22'd0, exp_q.pop_front()});
    end
  end

  // Drive nb bits of w (MSB first); keep SS_n low afterwards if keep is set.
  task automatic frame(input logic [9:0] w, input int nb, input bit keep);
    if (nb == 10) exp_q.push_back(w);
    SS_n = 1'b0;
    tick;
    for (int i = 0; i < nb; i++) begin
      MOSI = w[9-i];
      tick;
      chk("rx_valid_timing", {31'd0, rx_valid}, {31'd0, (nb == 10 && i == nb - 1)});
      chk("miso_quiet_rx", {31'd0, MISO}, 32'd0);
    end
    MOSI = 1'b0;
    if (!keep) begin
      SS_n = 1'b1;
      tick;
    end
  endtask

  // Called right after a kept frame completes: memory answers one cycle after
  // rx_valid, then MISO is sampled for n cycles (data if served, else zero).
  task automatic serve(input logic [7:0] d, input bit served, input int n);
    tick;
    tx_valid = 1'b1;
    tx_data  = d;
    if (served) for (int k = 0; k < 8; k++) miso_q.push_back(d[7-k]);
    tick;
    tx_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (served && miso_q.size() != 0) chk("miso_bit", {31'd0, MISO}, {31'd0, miso_q.pop_front()});
      else                              chk("miso_zero", {31'd0, MISO}, 32'd0);
      tick;
    end
    if (served && n == 8) chk("miso_after_shift", {31'd0, MISO}, 32'd0);
  endtask

  initial begin
    tick;
    tick;
    chk("reset_miso", {31'd0, MISO}, 32'd0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_rx_data", {22'd0, rx_data}, 32'd0);
    rst_n = 1'b1;

    // Write-address and write-data frames.
    frame(10'h03C, 10, 1'b0);
    chk("rv_count_wa", rv_cnt, 1);
    frame(10'h1A5, 10, 1'b0);
    chk("rv_count_wd", rv_cnt, 2);

    // Read address (held still clear -> READ_ADD, no MISO), then read data.
    frame(10'h23C, 10, 1'b1);
    serve(8'h5A, 1'b0, 9);
    SS_n = 1'b1;
    tick;
    frame(10'h300, 10, 1'b1);
    serve(8'hA5, 1'b1, 8);
    tx_valid = 1'b1;  // second tx_valid in the same frame must be ignored
    tx_data  = 8'hFF;
    tick;
    tx_valid = 1'b0;
    chk("second_tx_valid", {31'd0, MISO}, 32'd0);
    tick;
    chk("second_tx_valid2", {31'd0, MISO}, 32'd0);
    SS_n = 1'b1;
    tick;
    chk("rv_count_rd", rv_cnt, 4);

    // Abort a write frame after 5 bits: rx_data must not move.
    frame(10'h0FF, 5, 1'b0);
    chk("abort_rv_count", rv_cnt, 4);
    chk("abort_rx_hold", {22'd0, rx_data}, 32'h300);
    frame(10'h011, 10, 1'b0);
    chk("after_abort_rv", rv_cnt, 5);

    // Abort during MISO shift.
    frame(10'h2C3, 10, 1'b1);
    serve(8'hFF, 1'b0, 2);
    SS_n = 1'b1;
    tick;
    frame(10'h300, 10, 1'b1);
    serve(8'hC3, 1'b1, 3);
    SS_n = 1'b1;
    miso_q.delete();
    tick;
    chk("miso_abort", {31'd0, MISO}, 32'd0);
    tick;
    chk("miso_abort_idle", {31'd0, MISO}, 32'd0);
    frame(10'h255, 10, 1'b1);  // held was cleared by the 11 frame -> READ_ADD
    serve(8'hFF, 1'b0, 9);
    SS_n = 1'b1;
    tick;

    // Reset in the middle of a read-data frame (held is 1 here).
    frame(10'h300, 6, 1'b1);
    rst_n = 1'b0;
    tick;
    chk("midrst_miso", {31'd0, MISO}, 32'd0);
    chk("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("midrst_rx_data", {22'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    SS_n  = 1'b1;
    tick;
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick;
    tx_valid = 1'b0;
    chk("idle_tx_valid", {31'd0, MISO}, 32'd0);
    tick;
    chk("idle_tx_valid2", {31'd0, MISO}, 32'd0);
    frame(10'h3C3, 10, 1'b1);  // held cleared by reset -> READ_ADD, MISO silent
    serve(8'hFF, 1'b0, 9);
    SS_n = 1'b1;
    tick;
    tick;

    chk("final_rv_count", rv_cnt, 9);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
